initiator_port: RTL and testbench
=================================

INITIATOR_PORT -- requirements
Module: initiator_port

Parameters
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, meaning cycles allowed in ACK_WAIT before abort (range 1..255).

Interface
REQ-002 SHALL have clk  in  1  rising-edge clock; all state changes on posedge clk.
REQ-003 SHALL have rst  in  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have init_req  in  1  request a transaction from the local initiator.
REQ-005 SHALL have init_addr  in  16  target address.
REQ-006 SHALL have init_wdata  in  8  write data.
REQ-007 SHALL have init_rw  in  1  1 write, 0 read.
REQ-008 SHALL have init_ready  out  1  high only in IDLE; accept when init_req && init_ready.
REQ-009 SHALL have init_rdata  out  8  read data; init_rdata_valid  out  1  one-cycle pulse.
REQ-010 SHALL have init_done  out  1  one-cycle completion pulse; init_error  out  1  one-cycle abort pulse.
REQ-011 SHALL have arbiter_req  out  1  bus request; arbiter_grant  in  1  grant, also split re-grant.
REQ-012 SHALL have bus_data_out  out  1  serial bit; bus_data_out_valid  out  1  bit qualifier; bus_mode  out  1  1 data, 0 address; bus_rw  out  1  latched init_rw.
REQ-013 SHALL have bus_data_in  in  1  serial read bit; bus_data_in_valid  in  1  qualifier; bus_target_ack  in  1; bus_split_ack  in  1.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, ADDR, ACK_WAIT, WDATA, RDATA, SPLIT, DONE.
REQ-015 SHALL, on init_req && init_ready, latch init_addr/init_wdata/init_rw and enter REQ next cycle; init_* inputs ignored outside IDLE.
REQ-016 SHALL assert arbiter_req in REQ, ADDR, ACK_WAIT, WDATA, RDATA; deasserted in IDLE, SPLIT, DONE.
REQ-017 SHALL remain in REQ until arbiter_grant=1, then enter ADDR; grant ignored in all other states except SPLIT.
REQ-018 SHALL in ADDR drive 16 address bits LSB first, one per cycle, bus_mode=0, bus_data_out_valid=1, using 4-bit counter; after bit 15 enter ACK_WAIT.
REQ-019 SHALL in ACK_WAIT count cycles; bus_target_ack=1 -> WDATA if write, RDATA if read; counter reaching ACK_TIMEOUT without ack -> pulse init_error and init_done, return IDLE.
REQ-020 SHALL give ack priority over timeout when both occur in the same cycle.
REQ-021 SHALL in WDATA drive 8 data bits LSB first, bus_mode=1, bus_data_out_valid=1; after bit 7 enter DONE.
REQ-022 SHALL in RDATA shift bus_data_in into bit position rx_count only when bus_data_in_valid=1, LSB first; after the 8th valid bit enter DONE.
REQ-023 SHALL in RDATA with rx_count=0 and bus_split_ack=1 (no bit valid) enter SPLIT; bus_split_ack with rx_count>0 ignored.
REQ-024 SHALL in SPLIT wait for arbiter_grant=1, then return to RDATA with rx_count=0.
REQ-025 SHALL in DONE pulse init_done for one cycle; for reads also load init_rdata and pulse init_rdata_valid same cycle; next state IDLE.
REQ-026 SHALL hold bus_data_out_valid=0, bus_mode=0, bus_data_out=0 outside ADDR/WDATA.
REQ-027 SHALL hold init_rdata value until next completed read.

Reset
REQ-028 SHALL when rst=1 at posedge force IDLE, clear counters and latches; all outputs 0 except init_ready=1; reset mid-transaction aborts without init_done or init_error.

Verification
REQ-029 Write 0xA5 to 0x1234, grant 2 cycles after request, ack after 3 -> addr bits 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0 with bus_mode=0, then 1,0,1,0,0,1,0,1 with bus_mode=1; init_done one pulse.
REQ-030 Read 0x00FF, target returns 0x3C with gaps in bus_data_in_valid -> init_rdata=0x3C, init_rdata_valid and init_done coincident one cycle.
REQ-031 Read with bus_split_ack after ack -> arbiter_req drops in SPLIT; re-grant 10 cycles later -> arbiter_req reasserts, read of 0x81 completes correctly.
REQ-032 No ack, ACK_TIMEOUT=16 -> init_error and init_done pulse exactly 16 cycles after ACK_WAIT entry; init_ready high next cycle.
REQ-033 Ack arriving on the timeout cycle -> no init_error; transfer proceeds.
REQ-034 rst during WDATA bit 3 -> next cycle IDLE, arbiter_req=0, bus_data_out_valid=0, no init_done; subsequent write completes normally.

Source files
------------

// File: rtl/initiator_port.sv
// initiator_port: serial bus initiator with arbitration, ack timeout and split reads
module initiator_port #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  input  logic [15:0] init_addr,
  input  logic [7:0]  init_wdata,
  input  logic        init_rw,
  output logic        init_ready,
  output logic [7:0]  init_rdata,
  output logic        init_rdata_valid,
  output logic        init_done,
  output logic        init_error,
  output logic        arbiter_req,
  input  logic        arbiter_grant,
  output logic        bus_data_out,
  output logic        bus_data_out_valid,
  output logic        bus_mode,
  output logic        bus_rw,
  input  logic        bus_data_in,
  input  logic        bus_data_in_valid,
  input  logic        bus_target_ack,
  input  logic        bus_split_ack
);
  localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, ADDR = 3'd2, ACK_WAIT = 3'd3,
                         WDATA = 3'd4, RDATA = 3'd5, SPLIT = 3'd6, DONE = 3'd7;
  logic [2:0]  state_q, state_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  to_q, to_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d, rx_q, rx_d, rdata_q, rdata_d;
  logic        rw_q, rw_d, err_q, err_d;
  // next-state logic: bit_q serves as the address/write bit index and the read rx_count
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    to_d    = to_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (init_req) begin
        state_d = REQ;
        addr_d  = init_addr;
        wdata_d = init_wdata;
        rw_d    = init_rw;
      end
      REQ: if (arbiter_grant) begin
        state_d = ADDR;
        bit_d   = 4'd0;
      end
      ADDR: begin
        state_d = (bit_q == 4'd15) ? ACK_WAIT : ADDR;
        bit_d   = bit_q + 4'd1;
        to_d    = 8'd0;
      end
      ACK_WAIT: if (bus_target_ack) begin
        state_d = rw_q ? WDATA : RDATA;
        bit_d   = 4'd0;
      end else if (to_q == 8'(ACK_TIMEOUT - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        to_d = to_q + 8'd1;
      end
      WDATA: begin
        state_d = (bit_q == 4'd7) ? DONE : WDATA;
        bit_d   = bit_q + 4'd1;
      end
      RDATA: if (bus_data_in_valid) begin
        rx_d[bit_q[2:0]] = bus_data_in;
        state_d = (bit_q == 4'd7) ? DONE : RDATA;
        rdata_d = (bit_q == 4'd7) ? rx_d : rdata_q;
        bit_d   = bit_q + 4'd1;
      end else if (bit_q == 4'd0 && bus_split_ack) begin
        state_d = SPLIT;
      end
      SPLIT: if (arbiter_grant) begin
        state_d = RDATA;
        bit_d   = 4'd0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset drops any transaction silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      to_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      to_q    <= to_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
    end
  end
  assign init_ready         = state_q == IDLE;
  assign arbiter_req        = state_q inside {REQ, ADDR, ACK_WAIT, WDATA, RDATA};
  assign bus_data_out_valid = state_q == ADDR || state_q == WDATA;
  assign bus_mode           = state_q == WDATA;
  assign bus_data_out       = (state_q == ADDR) ? addr_q[bit_q] :
                              (state_q == WDATA) ? wdata_q[bit_q[2:0]] : 1'b0;
  assign bus_rw             = rw_q;
  assign init_done          = state_q == DONE || err_q;
  assign init_error         = err_q;
  assign init_rdata_valid   = state_q == DONE && !rw_q;
  assign init_rdata         = rdata_q;
endmodule

// File: tb/tb_initiator_port.sv
// tb_initiator_port: transaction-level checks of initiator_port with directed and random traffic
module tb_initiator_port;
  localparam int ACK_TO = 16;
  logic        clk = 0, rst = 1;
  logic        init_req = 0, init_rw = 0;
  logic [15:0] init_addr = 0;
  logic [7:0]  init_wdata = 0;
  logic        init_ready, init_rdata_valid, init_done, init_error;
  logic [7:0]  init_rdata;
  logic        arbiter_req, arbiter_grant = 0;
  logic        bus_data_out, bus_data_out_valid, bus_mode, bus_rw;
  logic        bus_data_in = 0, bus_data_in_valid = 0, bus_target_ack = 0, bus_split_ack = 0;
  int          n_chk = 0, n_err = 0;
  logic [7:0]  last_rd = 0;

  initiator_port #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst(rst),
    .init_req(init_req), .init_addr(init_addr), .init_wdata(init_wdata), .init_rw(init_rw),
    .init_ready(init_ready), .init_rdata(init_rdata), .init_rdata_valid(init_rdata_valid),
    .init_done(init_done), .init_error(init_error),
    .arbiter_req(arbiter_req), .arbiter_grant(arbiter_grant),
    .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
    .bus_mode(bus_mode), .bus_rw(bus_rw),
    .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid),
    .bus_target_ack(bus_target_ack), .bus_split_ack(bus_split_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one whole transaction; the expected bus stream and pulse timing come from the transaction fields
  task automatic txn(input bit rw, input logic [15:0] a, input logic [7:0] wd, input int gdly,
                     input int adly, input logic [7:0] rd, input bit split, input int sdly,
                     input int rst_bit);
    logic [15:0] ga;
    logic [7:0]  gw;
    int          bad, nv, cyc;
    ga = 0; gw = 0; bad = 0;
    chk("ready_idle", 32'(init_ready), 1);
    chk("rdata_hold", 32'(init_rdata), 32'(last_rd));
    init_req = 1; init_addr = a; init_wdata = wd; init_rw = rw;
    step();
    init_req = 0; init_addr = 16'($urandom); init_wdata = 8'($urandom); init_rw = 1'($urandom);
    chk("req_arb", 32'(arbiter_req), 1);
    chk("req_ready", 32'(init_ready), 0);
    chk("bus_rw", 32'(bus_rw), 32'(rw));
    repeat (gdly) step();
    arbiter_grant = 1;
    step();
    arbiter_grant = 0;
    for (int i = 0; i < 16; i++) begin
      ga[i] = bus_data_out;
      if (!bus_data_out_valid || bus_mode || !arbiter_req) bad++;
      step();
    end
    chk("addr_bits", 32'(ga), 32'(a));
    chk("addr_qual", bad, 0);
    for (int c = 0; c < ACK_TO; c++) begin
      if (!arbiter_req || bus_data_out_valid || init_done) bad++;
      bus_target_ack = (c == adly);
      step();
      bus_target_ack = 0;
      if (c == adly) break;
    end
    chk("ackwait_qual", bad, 0);
    if (adly >= ACK_TO) begin
      chk("to_error", 32'(init_error), 1);
      chk("to_done", 32'(init_done), 1);
      chk("to_ready", 32'(init_ready), 1);
      chk("to_arb", 32'(arbiter_req), 0);
      step();
      chk("to_error_pulse", 32'(init_error), 0);
      chk("to_done_pulse", 32'(init_done), 0);
      return;
    end
    chk("no_error", 32'(init_error), 0);
    if (rw) begin
      for (int i = 0; i < 8; i++) begin
        if (i == rst_bit) begin
          rst = 1;
          step();
          rst = 0;
          chk("rst_ready", 32'(init_ready), 1);
          chk("rst_arb", 32'(arbiter_req), 0);
          chk("rst_valid", 32'(bus_data_out_valid), 0);
          chk("rst_done", 32'(init_done), 0);
          chk("rst_error", 32'(init_error), 0);
          last_rd = 0;
          return;
        end
        gw[i] = bus_data_out;
        if (!bus_data_out_valid || !bus_mode || !arbiter_req) bad++;
        step();
      end
      chk("wdata_bits", 32'(gw), 32'(wd));
      chk("wdata_qual", bad, 0);
      chk("w_done", 32'(init_done), 1);
      chk("w_rvalid", 32'(init_rdata_valid), 0);
      chk("w_error", 32'(init_error), 0);
      chk("w_arb", 32'(arbiter_req), 0);
      chk("w_busvalid", 32'(bus_data_out_valid), 0);
      step();
      chk("w_done_pulse", 32'(init_done), 0);
      return;
    end
    if (split) begin
      bus_split_ack = 1;
      step();
      bus_split_ack = 0;
      chk("split_arb", 32'(arbiter_req), 0);
      repeat (sdly) begin
        if (arbiter_req) bad++;
        step();
      end
      arbiter_grant = 1;
      step();
      arbiter_grant = 0;
      chk("split_hold", bad, 0);
      chk("regrant_arb", 32'(arbiter_req), 1);
    end
    nv = 0; cyc = 0;
    while (nv < 8) begin
      if (init_done || bus_data_out_valid || !arbiter_req) bad++;
      bus_data_in_valid = ($urandom_range(0, 2) != 0) || cyc > 30;
      bus_data_in = bus_data_in_valid ? rd[nv] : 1'($urandom);
      bus_split_ack = (nv > 0 && !bus_data_in_valid) ? 1'($urandom) : 1'b0;
      if (bus_data_in_valid) nv++;
      step();
      cyc++;
    end
    bus_data_in_valid = 0; bus_data_in = 0; bus_split_ack = 0;
    chk("rdata_qual", bad, 0);
    chk("r_done", 32'(init_done), 1);
    chk("r_rvalid", 32'(init_rdata_valid), 1);
    chk("r_rdata", 32'(init_rdata), 32'(rd));
    chk("r_arb", 32'(arbiter_req), 0);
    last_rd = rd;
    step();
    chk("r_rvalid_pulse", 32'(init_rdata_valid), 0);
    chk("r_done_pulse", 32'(init_done), 0);
    chk("r_rdata_hold", 32'(init_rdata), 32'(rd));
  endtask

  initial begin
    step();
    step();
    rst = 0;
    chk("rst_init_ready", 32'(init_ready), 1);
    chk("rst_outputs", 32'({init_rdata, init_rdata_valid, init_done, init_error, arbiter_req,
                            bus_data_out, bus_data_out_valid, bus_mode, bus_rw}), 0);
    txn(1, 16'h1234, 8'hA5, 2, 3, 8'h00, 0, 0, -1);
    txn(0, 16'h00FF, 8'h00, 1, 0, 8'h3C, 0, 0, -1);
    txn(0, 16'h4321, 8'h00, 0, 2, 8'h81, 1, 10, -1);
    txn(1, 16'hBEEF, 8'h5A, 1, 100, 8'h00, 0, 0, -1);
    txn(0, 16'h0F0F, 8'h00, 0, ACK_TO - 1, 8'hE7, 0, 0, -1);
    txn(1, 16'hCAFE, 8'h3C, 0, ACK_TO - 1, 8'h00, 0, 0, -1);
    txn(1, 16'h5555, 8'hC3, 3, 1, 8'h00, 0, 0, 3);
    txn(1, 16'hAAAA, 8'h96, 0, 0, 8'h00, 0, 0, -1);
    for (int k = 0; k < 25; k++) begin
      bit rw;
      rw = 1'($urandom);
      txn(rw, 16'($urandom), 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 20),
          8'($urandom), rw ? 1'b0 : 1'($urandom), $urandom_range(0, 5), -1);
      repeat ($urandom_range(0, 2)) step();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
